// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Contents:
//   PAR_NONE / PAR_EVEN / PAR_ODD : encodings of the PARITY parameter
//   MIN_DIV                       : smallest bit period the transmitter will use
//   tx_state_e                    : transmitter FSM state encoding
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // A bit period of 0 or 1 would break the per-bit counter, so the latched
  // divisor is clamped to at least this value.
  localparam int MIN_DIV = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en, wr_data   : write request; ignored while full
//   rd_en            : pop request; ignored while empty
//   rd_data          : head word, valid whenever empty = 0
//   full, empty      : occupancy flags, decoded from the registered count
//   count            : number of stored words (0..DEPTH)
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  // Flags come from the registered count, so a write while full is refused
  // even when a pop happens on the same edge.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with an input FIFO.
// Words written with i_Tx_DV are queued and sent LSB-first as
// start / DATA_BITS data / optional parity / STOP_BITS stop bits, each bit
// lasting the divisor latched from i_Clks_Per_Bit at the start of the frame.
// Ports:
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   i_Clks_Per_Bit     : bit period in clocks (values below 2 act as 2)
//   i_Tx_DV, i_Tx_Byte : write strobe and data word
//   o_Tx_Ready         : FIFO not full
//   o_Tx_Overrun       : one-cycle pulse after a write attempted while not ready
//   o_Fifo_Count       : FIFO occupancy
//   o_Tx_Serial        : registered serial line, idles high
//   o_Tx_Active        : a frame is in progress
//   o_Tx_Done          : high during the final stop-bit cycle of each frame
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic [DIV_WIDTH-1:0]          i_Clks_Per_Bit,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done
);

  // One extra bit so that the two-stop-bit length (2 x divisor) cannot wrap.
  localparam int CNT_W = DIV_WIDTH + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   serial_q, serial_d;
  logic                   overrun_q, overrun_d;

  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0]   fifo_head;
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [CNT_W-1:0]       bit_last, stop_last;
  logic                   parity_bit;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clock),
    .rst_n   (i_Reset_n),
    .wr_en   (i_Tx_DV),
    .wr_data (i_Tx_Byte),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_Fifo_Count)
  );

  assign fifo_pop   = (state_q == S_IDLE);
  assign o_Tx_Ready = ~fifo_full;
  assign overrun_d  = i_Tx_DV & fifo_full;

  assign div_eff    = (i_Clks_Per_Bit < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV)
                                                             : i_Clks_Per_Bit;
  assign bit_last   = {1'b0, div_q} - CNT_W'(1);
  assign stop_last  = (STOP_BITS == 2) ? ({div_q, 1'b0} - CNT_W'(1)) : bit_last;

  // State register together with the per-frame datapath registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      div_q     <= DIV_WIDTH'(MIN_DIV);
      serial_q  <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      div_q     <= div_d;
      serial_q  <= serial_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic. cnt_q counts clocks inside the current bit (or inside
  // the whole stop field) and the state advances on its last value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    div_d     = div_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          data_d    = fifo_head;
          div_d     = div_eff;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q == bit_last) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == bit_last) begin
          cnt_d = '0;
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == bit_last) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == stop_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign parity_bit = (PARITY == PAR_ODD) ? ~(^data_d) : ^data_d;

  // Output logic. The line value is decoded from the next state so that the
  // serial register shows each bit in the same cycles the FSM spends on it.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = data_d[bit_idx_d];
      S_PARITY: serial_d = parity_bit;
      default:  serial_d = 1'b1;
    endcase
  end

  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Overrun = overrun_q;
  assign o_Tx_Active  = (state_q != S_IDLE);
  assign o_Tx_Done    = (state_q == S_STOP) && (cnt_q == stop_last);

endmodule
